// File: rtl/rs_syndrome_calc.sv
// RS(255,239) syndrome calculator over GF(2^8): Horner accumulation of NSYN syndromes, one symbol per clock.
// Optional macro RS_SYN_ERR_CNT_EN adds a saturating err_frames counter of frames with nonzero syndromes.
module rs_syndrome_calc #(
    parameter int         N         = 255,
    parameter int         NSYN      = 16,
    parameter int         FCR       = 0,
    parameter logic [8:0] PRIM_POLY = 9'h11D
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sym_valid,
    input  logic                sym_sop,
    input  logic [7:0]          sym_in,
    output logic                syn_valid,
    output logic [NSYN*8-1:0]   syn_out,
    output logic                err_flag,
    output logic                frame_err
`ifdef RS_SYN_ERR_CNT_EN
    ,
    output logic [15:0]         err_frames
`endif
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? PRIM_POLY[7:0] : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int k = 0; k < 8; k++) begin
            p = p ^ (b[k] ? t : 8'h00);
            t = gf_xtime(t);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_alpha_pow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 0; k < (e % 255); k++) begin
            r = gf_xtime(r);
        end
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NSYN-1:0][7:0]   acc_q, acc_d;
    logic [NSYN-1:0][7:0]   acc_next_s;
    logic [NSYN*8-1:0]      syn_out_q, syn_out_d;
    logic                   syn_valid_q, syn_valid_d;
    logic                   err_flag_q, err_flag_d;
    logic                   frame_err_q, frame_err_d;
    logic                   in_accum_s;
    logic                   last_s;
`ifdef RS_SYN_ERR_CNT_EN
    logic [15:0]            err_frames_q, err_frames_d;
`endif

    // Each root multiplier has a fixed constant, so gf_mul folds to a pure XOR network.
    for (genvar g = 0; g < NSYN; g++) begin : g_root
        localparam logic [7:0] ROOT = gf_alpha_pow(FCR + g);
        assign acc_next_s[g] = gf_mul(acc_q[g], ROOT) ^ sym_in;
    end

    assign in_accum_s = (state_q == ACCUM) && sym_valid;
    assign last_s     = (cnt_q == CW'(N - 1));

    // State register and all flops, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            syn_out_q   <= '0;
            syn_valid_q <= 1'b0;
            err_flag_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef RS_SYN_ERR_CNT_EN
            err_frames_q <= 16'h0000;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            syn_out_q   <= syn_out_d;
            syn_valid_q <= syn_valid_d;
            err_flag_q  <= err_flag_d;
            frame_err_q <= frame_err_d;
`ifdef RS_SYN_ERR_CNT_EN
            err_frames_q <= err_frames_d;
`endif
        end
    end

    // Next-state, counter and accumulator update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (sym_valid && sym_sop) begin
                    acc_d   = {NSYN{sym_in}};
                    cnt_d   = CW'(1);
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (sym_valid && sym_sop) begin
                    acc_d   = {NSYN{sym_in}};
                    cnt_d   = CW'(1);
                    state_d = ACCUM;
                end else if (sym_valid) begin
                    acc_d   = acc_next_s;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = last_s ? IDLE : ACCUM;
                end else begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output register next values: pulses default low, result registers hold.
    always_comb begin
        syn_valid_d = 1'b0;
        frame_err_d = 1'b0;
        syn_out_d   = syn_out_q;
        err_flag_d  = err_flag_q;
        if (in_accum_s && sym_sop) begin
            frame_err_d = 1'b1;
        end else if (in_accum_s && last_s) begin
            syn_valid_d = 1'b1;
            syn_out_d   = acc_next_s;
            err_flag_d  = |acc_next_s;
        end else begin
            syn_valid_d = 1'b0;
        end
`ifdef RS_SYN_ERR_CNT_EN
        if (syn_valid_d && err_flag_d && (err_frames_q != 16'hFFFF)) begin
            err_frames_d = err_frames_q + 16'h0001;
        end else begin
            err_frames_d = err_frames_q;
        end
`endif
    end

    assign syn_valid = syn_valid_q;
    assign syn_out   = syn_out_q;
    assign err_flag  = err_flag_q;
    assign frame_err = frame_err_q;
`ifdef RS_SYN_ERR_CNT_EN
    assign err_frames = err_frames_q;
`endif

endmodule

// File: doc/rs_syndrome_calc.md
Name: rs_syndrome_calc

Overview:
Downstream receive-side stage for the RS(255,239) codec over GF(2^8) with primitive polynomial 0x11D.
- Consumes one 8-bit received symbol per accepted clock, highest-degree symbol first, in the same symbol order the encoder emits.
- Computes the 2t = 16 syndromes S_i = r(alpha^(FCR+i)) by Horner accumulation.
- Presents the syndrome vector plus an error flag for the later key-equation and Chien stages.

Parameters:
- N, 255: codeword length in symbols.
- NSYN, 16: number of syndromes (2t).
- FCR, 0: first consecutive root exponent; root i is alpha^(FCR+i).
- PRIM_POLY, 9'h11D: GF(2^8) field polynomial used by the constant multipliers.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sym_valid  input  1  sym_in and sym_sop are valid this cycle.
- sym_sop  input  1  first symbol of a codeword; qualified by sym_valid.
- sym_in  input  8  received symbol.
- syn_valid  output  1  one-cycle pulse; syn_out, err_flag and frame_err are valid.
- syn_out  output  NSYN*8  syndromes packed as S_0 in [7:0], S_i in [8i+7:8i].
- err_flag  output  1  at least one syndrome is nonzero; qualified by syn_valid.
- frame_err  output  1  one-cycle pulse: a codeword was aborted by an early sym_sop.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; symbol counter goes to 0.
  - Accumulators are cleared.
  - syn_valid, err_flag, frame_err and syn_out all go to 0.
  - Reset mid-frame discards the partial frame; no syn_valid is produced for it.
- States:
  - IDLE: waits for sym_valid & sym_sop. That symbol loads every accumulator: S_i <= sym_in. Counter <= 1. Next state is ACCUM.
    - In IDLE, symbols with sym_valid=1 and sym_sop=0 are dropped silently.
  - ACCUM: on each sym_valid & !sym_sop, S_i <= (S_i * alpha^(FCR+i)) XOR sym_in and the counter increments.
    - Cycles with sym_valid=0 are stalls: accumulators and counter hold.
    - When the symbol completing count N is accepted, the next cycle has syn_valid=1, syn_out = the final S_i, and err_flag = OR of all final syndromes.
    - The FSM returns to IDLE in that same cycle.
  - Early sym_sop in ACCUM (sym_valid & sym_sop before count N):
    - Pulse frame_err the next cycle.
    - Discard the partial frame; no syn_valid.
    - Restart accumulation with this symbol: S_i <= sym_in, counter <= 1. Stay in ACCUM.
- Latency: syn_valid is asserted exactly 1 clk after the Nth symbol is accepted.
- Output registers:
  - syn_out and err_flag are held registers. They keep their last values until the next syn_valid.
  - syn_valid and frame_err are single-cycle pulses.
- Back-to-back frames:
  - A sym_sop in the cycle directly after the Nth symbol (while syn_valid is high) starts a new frame with no lost symbol.
  - Output registers are separate from the accumulators, so the zero-gap stream at 1 symbol/clk is sustained.
- Arithmetic:
  - GF multiply by the constant alpha^(FCR+i) is a combinational XOR network derived from PRIM_POLY.
  - Exponents are taken mod 255. Addition is bitwise XOR.
- Counter:
  - Width is ceil(log2(N+1)).
  - The counter never wraps; the compare is against N.
- sym_in is ignored whenever sym_valid=0.

Optional Feature:
- Macro: RS_SYN_ERR_CNT_EN.
- When defined:
  - Adds output port err_frames [15:0].
  - err_frames increments by 1 in the cycle syn_valid=1 and err_flag=1.
  - It saturates at 16'hFFFF.
  - It clears to 0 on rst.
  - Frames aborted via frame_err are not counted.
- When undefined: the port and the counter do not exist. All other behaviour is identical.

Test Plan:
- All-zero codeword: sop + 255 symbols of 0x00 at 1/clk -> syn_valid high exactly 1 clk after the 255th symbol; syn_out = 0; err_flag = 0.
- Single error at degree 0: 254 zeros then 0x5A as the last symbol -> every S_i = 0x5A; err_flag = 1.
- Single error at degree 1: symbol 254 = 0x01, all others 0 -> S_0..S_7 = 01,02,04,08,10,20,40,80; S_8 = 0x1D; S_9 = 0x3A.
- Valid codeword from the encoder with random stalls (sym_valid toggling ~50%) -> syn_out = 0, err_flag = 0, single syn_valid pulse; outputs match the no-stall run.
- Early sop at symbol 100, then a full zero frame -> frame_err pulse at cycle 101, no syn_valid for the aborted frame, then one syn_valid with syn_out = 0.
- rst asserted at symbol 50, then back-to-back frames (zero frame, then a frame with the last symbol 0x5A) -> no output from the aborted frame; two syn_valid pulses 255 clk apart. With RS_SYN_ERR_CNT_EN defined, err_frames = 1 after the second pulse.
